// File: rtl/sram_write_ctrl_pkg.sv
// sram_write_ctrl_pkg: shared widths, FIFO depth default and FSM encoding for the SRAM write driver
package sram_write_ctrl_pkg;
  localparam int BIT_DATA = 16;
  localparam int SRAM_ADDR_W = 10;
  localparam int FIFO_DEPTH_DEF = 4;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/sram_write_ctrl_sync_fifo.sv
// sram_write_ctrl_sync_fifo: staging FIFO with registered full/empty flags and async active-low reset
module sram_write_ctrl_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clka,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] cnt, cnt_nxt;
  assign cnt_nxt = cnt + (AW+1)'(push) - (AW+1)'(pop);
  assign dout = mem[rd_ptr];
  always_ff @(posedge clka or negedge rstn)
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt_nxt;
      full <= cnt_nxt == (AW+1)'(DEPTH);
      empty <= cnt_nxt == '0;
    end
  always_ff @(posedge clka)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/sram_write_ctrl.sv
// sram_write_ctrl: stages a LEN-word stream in a FIFO and writes it to SRAM port A at BASE..BASE+LEN-1
module sram_write_ctrl
  import sram_write_ctrl_pkg::*;
#(
  parameter int WIDTH = BIT_DATA,
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clka,
  input  logic              rstn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              hold,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [WIDTH-1:0]  dina,
  output logic              busy,
  output logic              done
);
  state_t state;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0] len_q, acc_cnt, wr_cnt;
  logic full, empty, push, pop;
  logic [WIDTH-1:0] head;
  assign s_ready = state == ST_RUN && !full && acc_cnt < len_q;
  assign push = s_valid && s_ready;
  assign pop = state == ST_RUN && !empty && !hold;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  sram_write_ctrl_sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clka(clka),
    .rstn(rstn),
    .push(push),
    .pop(pop),
    .din(s_data),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clka or negedge rstn)
    if (!rstn) begin
      state <= ST_IDLE;
      base_q <= '0;
      len_q <= '0;
      acc_cnt <= '0;
      wr_cnt <= '0;
      ena <= 1'b0;
      wea <= 1'b0;
      addra <= '0;
      dina <= '0;
    end else begin
      ena <= pop;
      wea <= pop;
      dina <= pop ? head : '0;
      if (pop) addra <= base_q + wr_cnt[ADDR_W-1:0];
      if (push) acc_cnt <= acc_cnt + (ADDR_W+1)'(1);
      if (pop) wr_cnt <= wr_cnt + (ADDR_W+1)'(1);
      if (state == ST_IDLE && start) begin
        base_q <= base_addr;
        len_q <= len;
        acc_cnt <= '0;
        wr_cnt <= '0;
        state <= len == '0 ? ST_DONE : ST_RUN;
      end else if (state == ST_RUN && pop && wr_cnt + (ADDR_W+1)'(1) == len_q)
        state <= ST_DONE;
      else if (state == ST_DONE)
        state <= ST_IDLE;
    end
endmodule

// File: tb/tb_sram_write_ctrl.sv
// tb_sram_write_ctrl: table-driven bursts with a write scoreboard plus reset and hold corner sequences
module tb_sram_write_ctrl;
  logic clka, rstn, start, hold, s_valid, s_ready, ena, wea, busy, done;
  logic [9:0] base_addr, addra;
  logic [10:0] len;
  logic [15:0] s_data, dina;
  typedef struct {
    logic [9:0]  base;
    logic [10:0] len;
    logic [15:0] seed;
    int          hat;
    int          hcy;
    bit          mid;
    logic [9:0]  exp_last;
  } vec_t;
  vec_t vt[7];
  logic [25:0] sb[$];
  logic [9:0] cur_base, last_addr;
  logic [10:0] cur_len;
  logic [15:0] cur_seed;
  int idx, writes, done_cnt, busy_cnt, checks, errors;
  sram_write_ctrl dut (
    .clka(clka),
    .rstn(rstn),
    .start(start),
    .base_addr(base_addr),
    .len(len),
    .hold(hold),
    .s_valid(s_valid),
    .s_data(s_data),
    .s_ready(s_ready),
    .ena(ena),
    .wea(wea),
    .addra(addra),
    .dina(dina),
    .busy(busy),
    .done(done)
  );
  initial clka = 1'b0;
  always #5 clka = ~clka;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask
  always @(negedge clka) begin
    logic [25:0] e;
    if (ena || wea) begin
      chk("ena_wea_pair", {30'd0, ena, wea}, 32'd3);
      if (sb.size() == 0)
        chk("unexpected_write", {22'd0, addra}, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("wr_addr", {22'd0, addra}, {22'd0, e[25:16]});
        chk("wr_data", {16'd0, dina}, {16'd0, e[15:0]});
      end
      writes++;
      last_addr = addra;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      chk("done_after_all_writes", writes, {21'd0, cur_len});
    end
  end
  task automatic cycle(input logic h, input logic st, input logic [9:0] b, input logic [10:0] l);
    @(negedge clka);
    hold = h;
    start = st;
    base_addr = b;
    len = l;
    s_valid = idx < int'(cur_len);
    s_data = cur_seed + 16'(idx);
    #1;
    if (s_valid && s_ready) begin
      sb.push_back({10'(cur_base + 10'(idx)), s_data});
      idx++;
    end
  endtask
  task automatic begin_burst(input logic [9:0] b, input logic [10:0] l, input logic [15:0] seed);
    cur_base = b;
    cur_len = l;
    cur_seed = seed;
    idx = 0;
    writes = 0;
    done_cnt = 0;
    busy_cnt = 0;
  endtask
  task automatic run_burst(input vec_t v, input string nm);
    bit fin;
    fin = 0;
    begin_burst(v.base, v.len, v.seed);
    for (int c = 0; c < 300 && !fin; c++) begin
      if (v.mid && c == 2)
        cycle(c >= v.hat && c < v.hat + v.hcy, 1'b1, 10'h2AA, 11'd5);
      else
        cycle(c >= v.hat && c < v.hat + v.hcy, c == 0, v.base, v.len);
      if (v.hcy > 5 && c == v.hat + v.hcy - 1)
        chk({nm, "_ready_low_on_full"}, {31'd0, s_ready}, 32'd0);
      fin = done_cnt > 0;
    end
    cycle(1'b0, 1'b0, 10'd0, 11'd0);
    chk({nm, "_writes"}, writes, {21'd0, v.len});
    chk({nm, "_done_pulses"}, done_cnt, 32'd1);
    chk({nm, "_idle_after"}, {30'd0, busy, done}, 32'd0);
    chk({nm, "_sb_empty"}, sb.size(), 32'd0);
    if (v.len == 0)
      chk({nm, "_busy_cycles"}, busy_cnt, 32'd1);
    else
      chk({nm, "_last_addr"}, {22'd0, last_addr}, {22'd0, v.exp_last});
  endtask
  initial begin
    vt[0] = '{10'h010, 11'd4,  16'h000A, 0, 0,  1'b0, 10'h013};
    vt[1] = '{10'h123, 11'd0,  16'h0000, 0, 0,  1'b0, 10'h000};
    vt[2] = '{10'h100, 11'd8,  16'h0100, 3, 10, 1'b0, 10'h107};
    vt[3] = '{10'h3FE, 11'd4,  16'h0055, 0, 0,  1'b0, 10'h001};
    vt[4] = '{10'h040, 11'd6,  16'h0077, 0, 0,  1'b1, 10'h045};
    vt[5] = '{10'h3FF, 11'd1,  16'hBEEF, 0, 0,  1'b0, 10'h3FF};
    vt[6] = '{10'h200, 11'd16, 16'hC000, 5, 3,  1'b0, 10'h20F};
    checks = 0;
    errors = 0;
    begin_burst(10'd0, 11'd0, 16'd0);
    start = 0;
    hold = 0;
    s_valid = 0;
    s_data = 0;
    base_addr = 0;
    len = 0;
    rstn = 1;
    #1 rstn = 0;
    @(negedge clka);
    @(negedge clka);
    chk("reset_outputs", {ena, wea, busy, done, s_ready, addra, dina}, 32'd0);
    rstn = 1;
    for (int i = 0; i < 7; i++) run_burst(vt[i], $sformatf("vec%0d", i));
    begin_burst(10'h050, 11'd6, 16'h0300);
    for (int c = 0; c < 50 && writes < 2; c++) cycle(1'b0, c == 0, 10'h050, 11'd6);
    #2 rstn = 0;
    #1 chk("midburst_reset_outputs", {ena, wea, busy, done, s_ready, addra, dina}, 32'd0);
    chk("midburst_writes_before_reset", writes, 32'd2);
    sb.delete();
    s_valid = 0;
    @(negedge clka);
    @(negedge clka);
    rstn = 1;
    chk("midburst_no_done", done_cnt, 32'd0);
    run_burst('{10'h060, 11'd2, 16'h0400, 0, 0, 1'b0, 10'h061}, "post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
